// File: rtl/bf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf_pkg
// Description : Shared types and constants for the BF interpreter core:
//               machine state encoding, error codes and opcode characters.
// Revision    : 1.0 - initial release
// ============================================================================
package bf_pkg;

    // Machine states (explicit 3-bit encoding)
    typedef enum logic [2:0] {
        ST_LOAD     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_SKIP     = 3'd2,
        ST_IN_WAIT  = 3'd3,
        ST_OUT_WAIT = 3'd4,
        ST_HALT     = 3'd5,
        ST_ERROR    = 3'd6
    } bf_state_e;

    // Fault codes reported on err_code
    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_STACK     = 2'd1,
        ERR_UNMATCHED = 2'd2,
        ERR_PTR       = 2'd3
    } bf_err_e;

    // Opcode characters (ASCII)
    localparam logic [7:0] c_op_inc   = 8'h2B;  // '+'
    localparam logic [7:0] c_op_dec   = 8'h2D;  // '-'
    localparam logic [7:0] c_op_right = 8'h3E;  // '>'
    localparam logic [7:0] c_op_left  = 8'h3C;  // '<'
    localparam logic [7:0] c_op_open  = 8'h5B;  // '['
    localparam logic [7:0] c_op_close = 8'h5D;  // ']'
    localparam logic [7:0] c_op_in    = 8'h2C;  // ','
    localparam logic [7:0] c_op_out   = 8'h2E;  // '.'

endpackage
`default_nettype wire

// File: rtl/bf_loop_stack.sv
`default_nettype none
// ============================================================================
// Module      : bf_loop_stack
// Description : LIFO of loop-start program addresses for the BF core.
//               Push is ignored when full, pop is ignored when empty; the
//               core checks o_full / o_empty itself to raise faults.
// Ports       : clk, rst        clock, asynchronous active-high reset
//               i_push/i_pop    push i_data / drop top entry
//               i_data          address to push
//               o_top           most recent entry ('0 when empty)
//               o_empty/o_full  occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module bf_loop_stack #(
    parameter int DEPTH = 15,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_sp_w = $clog2(DEPTH + 1);
    localparam logic [c_sp_w-1:0] c_full_sp = c_sp_w'(DEPTH);

    logic [c_sp_w-1:0] r_sp;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_sp_w-1:0] w_top_idx;

    assign w_top_idx = r_sp - 1'b1;
    assign o_empty   = (r_sp == '0);
    assign o_full    = (r_sp == c_full_sp);
    assign o_top     = o_empty ? '0 : r_mem[w_top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !o_full) begin
            r_mem[r_sp] <= i_data;
            r_sp        <= r_sp + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bf_core.sv
`default_nettype none
// ============================================================================
// Module      : bf_core
// Description : Parametrised BF interpreter. A program is streamed in over
//               the prog_* valid/ready port, then executes one instruction
//               per cycle. ',' and '.' block on valid/ready handshakes.
//               Supports cell wrap/saturate, pointer wrap/trap, and sticky
//               halt / error reporting.
// Ports       : clk, rst                      clock, async active-high reset
//               prog_in/valid/last, prog_ready program load stream
//               machine_input/valid, _ready    ',' input stream
//               machine_output/valid, _ready   '.' output stream
//               halted                         program ran off the end
//               error, err_code                fault flag and cause
// Revision    : 1.0 - initial release
// ============================================================================
module bf_core
    import bf_pkg::*;
#(
    parameter int WORD_SIZE      = 8,
    parameter int TAPE_LENGTH    = 16,
    parameter int PROGRAM_LENGTH = 256,
    parameter int MAX_DEPTH      = 15,
    parameter bit CELL_SAT       = 1'b0,
    parameter bit PTR_WRAP       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           prog_in,
    input  logic                 prog_valid,
    input  logic                 prog_last,
    output logic                 prog_ready,
    input  logic [WORD_SIZE-1:0] machine_input,
    input  logic                 machine_input_valid,
    output logic                 machine_input_ready,
    output logic [WORD_SIZE-1:0] machine_output,
    output logic                 machine_output_valid,
    input  logic                 machine_output_ready,
    output logic                 halted,
    output logic                 error,
    output logic [1:0]           err_code
);

    // pc and prog_len must be able to hold PROGRAM_LENGTH itself (end of program)
    localparam int c_pc_w    = $clog2(PROGRAM_LENGTH + 1);
    localparam int c_addr_w  = $clog2(PROGRAM_LENGTH);
    localparam int c_ptr_w   = $clog2(TAPE_LENGTH);
    localparam int c_depth_w = $clog2(PROGRAM_LENGTH + 1);

    localparam logic [c_pc_w-1:0]    c_last_len = c_pc_w'(PROGRAM_LENGTH - 1);
    localparam logic [c_ptr_w-1:0]   c_ptr_max  = c_ptr_w'(TAPE_LENGTH - 1);
    localparam logic [WORD_SIZE-1:0] c_cell_max = {WORD_SIZE{1'b1}};
    localparam logic [c_depth_w-1:0] c_depth_1  = c_depth_w'(1);

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    bf_state_e              r_state;
    bf_state_e              w_next_state;
    bf_err_e                r_err_code;
    bf_err_e                w_err_next;
    logic [c_pc_w-1:0]      r_pc;
    logic [c_pc_w-1:0]      w_pc_next;
    logic [c_pc_w-1:0]      w_pc_inc;
    logic [c_pc_w-1:0]      r_prog_len;
    logic [c_pc_w-1:0]      w_len_next;
    logic [c_ptr_w-1:0]     r_ptr;
    logic [c_ptr_w-1:0]     w_ptr_next;
    logic [c_depth_w-1:0]   r_depth;
    logic [c_depth_w-1:0]   w_depth_next;
    logic [WORD_SIZE-1:0]   r_out_data;
    logic [WORD_SIZE-1:0]   r_tape [TAPE_LENGTH];
    logic [7:0]             r_mem  [PROGRAM_LENGTH];

    logic [7:0]             w_char;
    logic [WORD_SIZE-1:0]   w_cell;
    logic [WORD_SIZE-1:0]   w_cell_next;
    logic                   w_cell_we;
    logic                   w_cell_zero;
    logic                   w_mem_we;
    logic                   w_out_load;
    logic                   w_push;
    logic                   w_pop;
    logic [c_addr_w-1:0]    w_top;
    logic                   w_stk_empty;
    logic                   w_stk_full;

    assign w_char      = r_mem[r_pc[c_addr_w-1:0]];
    assign w_cell      = r_tape[r_ptr];
    assign w_cell_zero = (w_cell == '0);
    assign w_pc_inc    = r_pc + 1'b1;

    // ------------------------------------------------------------------
    // Loop stack holds addresses of the '[' of each open loop
    // ------------------------------------------------------------------
    bf_loop_stack #(
        .DEPTH (MAX_DEPTH),
        .WIDTH (c_addr_w)
    ) u_loop_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_pc[c_addr_w-1:0]),
        .o_top   (w_top),
        .o_empty (w_stk_empty),
        .o_full  (w_stk_full)
    );

    // ------------------------------------------------------------------
    // Outputs are decoded from the state register so that an async reset
    // clears them without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign prog_ready           = (r_state == ST_LOAD);
    assign machine_input_ready  = (r_state == ST_IN_WAIT);
    assign machine_output_valid = (r_state == ST_OUT_WAIT);
    assign machine_output       = r_out_data;
    assign halted               = (r_state == ST_HALT);
    assign error                = (r_state == ST_ERROR);
    assign err_code             = r_err_code;

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_err_next   = r_err_code;
        w_pc_next    = r_pc;
        w_len_next   = r_prog_len;
        w_ptr_next   = r_ptr;
        w_depth_next = r_depth;
        w_cell_we    = 1'b0;
        w_cell_next  = w_cell;
        w_mem_we     = 1'b0;
        w_out_load   = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;

        case (r_state)
            ST_LOAD: begin
                if (prog_valid) begin
                    w_mem_we   = 1'b1;
                    w_len_next = r_prog_len + 1'b1;
                    // Memory full also terminates the load
                    if (prog_last || (r_prog_len == c_last_len)) begin
                        w_next_state = ST_EXEC;
                        w_pc_next    = '0;
                    end
                end
            end

            ST_EXEC: begin
                if (r_pc == r_prog_len) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_pc_next = w_pc_inc;
                    case (w_char)
                        c_op_inc: begin
                            w_cell_we   = 1'b1;
                            w_cell_next = (CELL_SAT && (w_cell == c_cell_max)) ? w_cell
                                                                              : w_cell + 1'b1;
                        end
                        c_op_dec: begin
                            w_cell_we   = 1'b1;
                            w_cell_next = (CELL_SAT && w_cell_zero) ? w_cell : w_cell - 1'b1;
                        end
                        c_op_right: begin
                            if (r_ptr != c_ptr_max) begin
                                w_ptr_next = r_ptr + 1'b1;
                            end else if (PTR_WRAP) begin
                                w_ptr_next = '0;
                            end else begin
                                w_next_state = ST_ERROR;
                                w_err_next   = ERR_PTR;
                            end
                        end
                        c_op_left: begin
                            if (r_ptr != '0) begin
                                w_ptr_next = r_ptr - 1'b1;
                            end else if (PTR_WRAP) begin
                                w_ptr_next = c_ptr_max;
                            end else begin
                                w_next_state = ST_ERROR;
                                w_err_next   = ERR_PTR;
                            end
                        end
                        c_op_open: begin
                            if (w_cell_zero) begin
                                w_next_state = ST_SKIP;
                                w_depth_next = c_depth_1;
                            end else if (w_stk_full) begin
                                w_next_state = ST_ERROR;
                                w_err_next   = ERR_STACK;
                            end else begin
                                w_push = 1'b1;
                            end
                        end
                        c_op_close: begin
                            if (w_stk_empty) begin
                                w_next_state = ST_ERROR;
                                w_err_next   = ERR_UNMATCHED;
                            end else if (!w_cell_zero) begin
                                // Jump to the instruction after the matching '['
                                // and leave the entry in place for the next pass.
                                w_pc_next = c_pc_w'(w_top) + 1'b1;
                            end else begin
                                w_pop = 1'b1;
                            end
                        end
                        c_op_in: begin
                            w_next_state = ST_IN_WAIT;
                            w_pc_next    = r_pc;
                        end
                        c_op_out: begin
                            w_next_state = ST_OUT_WAIT;
                            w_pc_next    = r_pc;
                            w_out_load   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            ST_SKIP: begin
                if (r_pc == r_prog_len) begin
                    w_next_state = ST_ERROR;
                    w_err_next   = ERR_UNMATCHED;
                end else begin
                    w_pc_next = w_pc_inc;
                    if (w_char == c_op_open) begin
                        w_depth_next = r_depth + 1'b1;
                    end else if (w_char == c_op_close) begin
                        w_depth_next = r_depth - 1'b1;
                        if (r_depth == c_depth_1) begin
                            w_next_state = ST_EXEC;
                        end
                    end
                end
            end

            ST_IN_WAIT: begin
                if (machine_input_valid) begin
                    w_cell_we    = 1'b1;
                    w_cell_next  = machine_input;
                    w_pc_next    = w_pc_inc;
                    w_next_state = ST_EXEC;
                end
            end

            ST_OUT_WAIT: begin
                if (machine_output_ready) begin
                    w_pc_next    = w_pc_inc;
                    w_next_state = ST_EXEC;
                end
            end

            default: ;  // HALT / ERROR are terminal
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers and tape
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_code <= ERR_NONE;
            r_pc       <= '0;
            r_prog_len <= '0;
            r_ptr      <= '0;
            r_depth    <= '0;
            r_out_data <= '0;
            for (int i = 0; i < TAPE_LENGTH; i++) begin
                r_tape[i] <= '0;
            end
        end else begin
            r_err_code <= w_err_next;
            r_pc       <= w_pc_next;
            r_prog_len <= w_len_next;
            r_ptr      <= w_ptr_next;
            r_depth    <= w_depth_next;
            if (w_out_load) begin
                r_out_data <= w_cell;
            end
            if (w_cell_we) begin
                r_tape[r_ptr] <= w_cell_next;
            end
        end
    end

    // Program memory is not reset; prog_len gates what is considered valid.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_prog_len[c_addr_w-1:0]] <= prog_in;
        end
    end

endmodule
`default_nettype wire
